// File: rtl/seeg_rec_ctrl_pkg.sv
// ============================================================================
// Module      : seeg_pkg
// Description : Shared types and constants for the sEEG recording controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seeg_pkg;

    localparam int C_DEF_NUM_CH      = 8;
    localparam int C_DEF_DATA_W      = 16;
    localparam int C_DEF_SAMPLE_DIV  = 39000;
    localparam int C_DEF_ADC_TIMEOUT = 64;
    localparam int C_FRAME_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONV      = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_WAIT_TICK = 2'd3
    } seeg_state_e;

endpackage

`default_nettype wire

// File: rtl/seeg_rec_ctrl_if.sv
// ============================================================================
// Module      : seeg_rec_ctrl_if
// Description : ADC conversion handshake plus valid/ready sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seeg_rec_ctrl_if #(
    parameter int CH_W   = 3,
    parameter int DATA_W = 16
);
    import seeg_pkg::*;

    logic                 adc_conv;
    logic [CH_W-1:0]      adc_ch;
    logic [DATA_W-1:0]    adc_data;
    logic                 adc_valid;
    logic [DATA_W-1:0]    m_data;
    logic [CH_W-1:0]      m_ch;
    logic [C_FRAME_W-1:0] m_frame;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output adc_conv, adc_ch, m_data, m_ch, m_frame, m_valid,
        input  adc_data, adc_valid, m_ready
    );

    modport slave (
        input  adc_conv, adc_ch, m_data, m_ch, m_frame, m_valid,
        output adc_data, adc_valid, m_ready
    );

endinterface

`default_nettype wire

// File: rtl/seeg_rec_ctrl_tick_gen.sv
// ============================================================================
// Module      : seeg_tick_gen
// Description : Frame-period divider; one-cycle tick on each wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seeg_tick_gen #(
    parameter int SAMPLE_DIV = seeg_pkg::C_DEF_SAMPLE_DIV
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic enable,
    output logic      tick
);

    localparam int                 C_CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(SAMPLE_DIV - 1);

    logic [C_CNT_W-1:0] r_cnt;

    // Held at zero while disabled so every recording session starts aligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!enable || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = enable && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/seeg_rec_ctrl.sv
// ============================================================================
// Module      : seeg_rec_ctrl
// Description : Frame-paced multi-channel sEEG ADC scan and sample streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seeg_rec_ctrl
    import seeg_pkg::*;
#(
    parameter int NUM_CH      = C_DEF_NUM_CH,
    parameter int DATA_W      = C_DEF_DATA_W,
    parameter int SAMPLE_DIV  = C_DEF_SAMPLE_DIV,
    parameter int ADC_TIMEOUT = C_DEF_ADC_TIMEOUT
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        record_start,
    input  wire logic        record_stop,
    seeg_rec_ctrl_if.master  bus,
    output logic             recording,
    output logic             overflow,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int                 CH_W       = $clog2(NUM_CH);
    localparam int                 C_TMO_W    = $clog2(ADC_TIMEOUT + 1);
    localparam logic [CH_W-1:0]    C_LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(ADC_TIMEOUT - 1);

    seeg_state_e          r_state, w_state_nxt;
    logic [CH_W-1:0]      r_ch;
    logic [C_FRAME_W-1:0] r_frame;
    logic [C_TMO_W-1:0]   r_tmo_cnt;
    logic                 r_stop_pending;
    logic                 r_overflow, r_overrun, r_timeout_err;
    logic [DATA_W-1:0]    r_m_data;
    logic [CH_W-1:0]      r_m_ch;
    logic [C_FRAME_W-1:0] r_m_frame;
    logic                 r_m_valid;
    logic                 w_tick, w_start, w_ch_done, w_capture, w_timeout, w_recording;

    assign w_recording = (r_state != ST_IDLE);
    assign w_capture   = (r_state == ST_WAIT_DATA) && bus.adc_valid;
    assign w_timeout   = (r_state == ST_WAIT_DATA) && !bus.adc_valid && (r_tmo_cnt == C_TMO_LAST);

    seeg_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
        .clk    (clk),
        .rstn   (rstn),
        .enable (w_recording),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ch_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (record_start && !record_stop) begin
                    w_state_nxt = ST_CONV;
                    w_start     = 1'b1;
                end
            end
            ST_CONV: w_state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                if (bus.adc_valid || w_timeout) begin
                    w_ch_done   = 1'b1;
                    w_state_nxt = (r_ch == C_LAST_CH) ? ST_WAIT_TICK : ST_CONV;
                end
            end
            ST_WAIT_TICK: begin
                // A stop request ends the session at the frame boundary.
                if (r_stop_pending || record_stop) w_state_nxt = ST_IDLE;
                else if (w_tick)                   w_state_nxt = ST_CONV;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ch           <= '0;
            r_frame        <= '0;
            r_tmo_cnt      <= '0;
            r_stop_pending <= 1'b0;
            r_overflow     <= 1'b0;
            r_overrun      <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else if (w_start) begin
            r_ch           <= '0;
            r_frame        <= '0;
            r_tmo_cnt      <= '0;
            r_stop_pending <= 1'b0;
            r_overflow     <= 1'b0;
            r_overrun      <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            if (w_ch_done)
                r_ch <= (r_ch == C_LAST_CH) ? '0 : r_ch + 1'b1;
            if ((r_state == ST_WAIT_TICK) && (w_state_nxt == ST_CONV))
                r_frame <= r_frame + 1'b1;
            if (r_state == ST_CONV)
                r_tmo_cnt <= '0;
            else if (r_state == ST_WAIT_DATA)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_state_nxt == ST_IDLE)
                r_stop_pending <= 1'b0;
            else if (w_recording && record_stop)
                r_stop_pending <= 1'b1;
            // A tick outside WAIT_TICK is lost; the scan resumes on the next one.
            if (w_tick && (r_state != ST_WAIT_TICK))
                r_overrun <= 1'b1;
            if (w_timeout)
                r_timeout_err <= 1'b1;
            if (w_capture && r_m_valid && !bus.m_ready)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_data  <= '0;
            r_m_ch    <= '0;
            r_m_frame <= '0;
            r_m_valid <= 1'b0;
        end else if (w_capture && (!r_m_valid || bus.m_ready)) begin
            r_m_data  <= bus.adc_data;
            r_m_ch    <= r_ch;
            r_m_frame <= r_frame;
            r_m_valid <= 1'b1;
        end else if (r_m_valid && bus.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.adc_conv = (r_state == ST_CONV);
    assign bus.adc_ch   = r_ch;
    assign bus.m_data   = r_m_data;
    assign bus.m_ch     = r_m_ch;
    assign bus.m_frame  = r_m_frame;
    assign bus.m_valid  = r_m_valid;
    assign recording    = w_recording;
    assign overflow     = r_overflow;
    assign overrun      = r_overrun;
    assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_seeg_rec_ctrl.sv
// ============================================================================
// Module      : tb_seeg_rec_ctrl
// Description : Directed self-checking bench for seeg_rec_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seeg_rec_ctrl;

    localparam int CH_W   = 2;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0, record_start = 1'b0, record_stop = 1'b0;
    logic recording, overflow, overrun, timeout_err;
    logic rstn2 = 1'b0, start2 = 1'b0, stop2 = 1'b0;
    logic rec2, ovf2, ovr2, tmo2;

    seeg_rec_ctrl_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus  ();
    seeg_rec_ctrl_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus2 ();

    seeg_rec_ctrl #(.NUM_CH(4), .DATA_W(DATA_W), .SAMPLE_DIV(100), .ADC_TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .record_start(record_start), .record_stop(record_stop),
        .bus(bus), .recording(recording), .overflow(overflow), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    // Short frame period: the scan cannot finish inside one period.
    seeg_rec_ctrl #(.NUM_CH(4), .DATA_W(DATA_W), .SAMPLE_DIV(16), .ADC_TIMEOUT(8)) dut_fast (
        .clk(clk), .rstn(rstn2), .record_start(start2), .record_stop(stop2),
        .bus(bus2), .recording(rec2), .overflow(ovf2), .overrun(ovr2),
        .timeout_err(tmo2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: answer 0x1000+ch three cycles after the conversion strobe.
    int         a1_cnt = 0, a2_cnt = 0;
    logic [1:0] a1_ch, a2_ch;
    logic [2:0] silent_ch = 3'b111;

    always @(negedge clk) begin
        bus.adc_valid = 1'b0;
        if (a1_cnt != 0) begin
            a1_cnt--;
            if (a1_cnt == 0) begin
                bus.adc_valid = 1'b1;
                bus.adc_data  = 16'h1000 + 16'(a1_ch);
            end
        end
        if (bus.adc_conv && ({1'b0, bus.adc_ch} != silent_ch)) begin
            a1_cnt = 3;
            a1_ch  = bus.adc_ch;
        end
        bus2.adc_valid = 1'b0;
        if (a2_cnt != 0) begin
            a2_cnt--;
            if (a2_cnt == 0) begin
                bus2.adc_valid = 1'b1;
                bus2.adc_data  = 16'h1000 + 16'(a2_ch);
            end
        end
        if (bus2.adc_conv) begin
            a2_cnt = 3;
            a2_ch  = bus2.adc_ch;
        end
    end

    logic [15:0] q_data[$], q_frame[$], q2_frame[$];
    logic [1:0]  q_ch[$], q2_ch[$], conv_ch[$];
    int          conv_cyc[$];

    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            q_data.push_back(bus.m_data);
            q_ch.push_back(bus.m_ch);
            q_frame.push_back(bus.m_frame);
        end
        if (bus.adc_conv) begin
            conv_cyc.push_back(cyc);
            conv_ch.push_back(bus.adc_ch);
        end
        if (bus2.m_valid && bus2.m_ready) begin
            q2_frame.push_back(bus2.m_frame);
            q2_ch.push_back(bus2.m_ch);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int qb, cb;

    initial begin
        bus.m_ready  = 1'b1;
        bus2.m_ready = 1'b1;
        step(3);
        chk("reset_flags", {recording, bus.adc_conv, bus.m_valid, overflow, overrun, timeout_err}, 0);
        chk("reset_out", {bus.m_data, bus.m_frame, 2'(bus.m_ch), 2'(bus.adc_ch)}, 0);
        rstn = 1'b1; rstn2 = 1'b1;
        step(2);

        // First frame: all four channels in order, tagged frame 0
        record_start = 1'b1; start2 = 1'b1;
        step(1);
        record_start = 1'b0; start2 = 1'b0;
        chk("rec_after_start", recording, 1);
        for (int i = 0; i < 100 && q_data.size() < 4; i++) step(1);
        chk("wait_frame0", q_data.size() >= 4, 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("frame0_out%0d", i), {q_frame[i], 2'(q_ch[i]), q_data[i]},
                {16'h0, 2'(i), 16'h1000 + 16'(i)});
        chk("frame0_conv_order", {conv_ch[0], conv_ch[1], conv_ch[2], conv_ch[3]}, 8'b00_01_10_11);
        for (int i = 0; i < 150 && conv_cyc.size() < 5; i++) step(1);
        chk("frame_period", conv_cyc[4] - conv_cyc[0], 100);

        // Stop in the middle of frame 2
        for (int i = 0; i < 150 && conv_cyc.size() < 9; i++) step(1);
        step(5);
        record_stop = 1'b1; stop2 = 1'b1;
        step(1);
        record_stop = 1'b0; stop2 = 1'b0;
        for (int i = 0; i < 100 && recording; i++) step(1);
        chk("stop_rec_low", recording, 0);
        step(150);
        chk("stop_out_count", q_data.size(), 12);
        chk("stop_last_out", {q_frame[11], 2'(q_ch[11]), q_data[11]}, {16'd2, 2'd3, 16'h1003});
        chk("stop_conv_count", conv_cyc.size(), 12);

        // Fast divider: overrun flagged, frame numbers contiguous
        chk("fast_flags", {rec2, ovr2, ovf2, tmo2}, 4'b0100);
        chk("fast_out_count", q2_frame.size() >= 16 && (q2_frame.size() % 4) == 0, 1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("fast_frame%0d", k), {q2_frame[4*k], 2'(q2_ch[4*k])}, {16'(k), 2'd0});

        // Silent channel 2: timeout and no output for it
        qb = q_data.size(); cb = conv_cyc.size();
        silent_ch = 3'd2;
        record_start = 1'b1;
        step(1);
        record_start = 1'b0;
        step(60);
        chk("tmo_flags", {timeout_err, overflow, overrun}, 3'b100);
        chk("tmo_out_count", q_data.size() - qb, 3);
        chk("tmo_out_ch", {2'(q_ch[qb]), 2'(q_ch[qb+1]), 2'(q_ch[qb+2])}, 6'b00_01_11);
        chk("tmo_out_data", q_data[qb+2], 16'h1003);
        chk("tmo_spacing", {8'(conv_cyc[cb+1] - conv_cyc[cb]), 8'(conv_cyc[cb+3] - conv_cyc[cb+2])},
            {8'd4, 8'd9});
        record_stop = 1'b1;
        step(1);
        record_stop = 1'b0;
        step(5);
        chk("tmo_stop", recording, 0);
        silent_ch = 3'b111;

        // Consumer stalled for the whole frame
        qb = q_data.size();
        bus.m_ready = 1'b0;
        record_start = 1'b1;
        step(1);
        record_start = 1'b0;
        step(40);
        record_stop = 1'b1;
        step(1);
        record_stop = 1'b0;
        step(5);
        chk("stall_held", {bus.m_valid, bus.m_data, bus.m_frame, 2'(bus.m_ch)}, {1'b1, 16'h1000, 16'h0, 2'd0});
        chk("stall_flags", {overflow, recording}, 2'b10);
        chk("stall_no_out", q_data.size() - qb, 0);
        bus.m_ready = 1'b1;
        step(5);
        chk("stall_one_out", q_data.size() - qb, 1);
        chk("stall_out_data", q_data[qb], 16'h1000);
        chk("stall_drained", bus.m_valid, 0);

        // Asynchronous reset while waiting on channel 1
        record_start = 1'b1;
        step(1);
        record_start = 1'b0;
        for (int i = 0; i < 50 && !(bus.adc_conv && bus.adc_ch == 2'd1); i++) step(1);
        chk("wait_ch1_conv", bus.adc_conv && bus.adc_ch == 2'd1, 1);
        step(1);
        rstn = 1'b0;
        #1;
        chk("rst_flags", {recording, bus.adc_conv, bus.m_valid, overflow, overrun, timeout_err}, 0);
        chk("rst_out", {bus.m_data, bus.m_frame, 2'(bus.m_ch), 2'(bus.adc_ch)}, 0);
        step(2);
        rstn = 1'b1;
        cb = conv_cyc.size();
        step(20);
        chk("rst_idle", {recording, 8'(conv_cyc.size() - cb)}, 0);
        record_start = 1'b1; record_stop = 1'b1;
        step(1);
        record_start = 1'b0; record_stop = 1'b0;
        step(10);
        chk("start_stop_idle", {recording, 8'(conv_cyc.size() - cb)}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seeg_rec_ctrl.md
SEEG_REC_CTRL -- requirements
Module: seeg_rec_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8: number of sEEG channels scanned per frame (2..64).
REQ-002 Parameter DATA_W, default 16: ADC sample width in bits.
REQ-003 Parameter SAMPLE_DIV, default 39000: clk cycles per frame period (1 kS/s per channel at 39 MHz); minimum NUM_CH*4.
REQ-004 Parameter ADC_TIMEOUT, default 64: max clk cycles from adc_conv to adc_valid.
REQ-005 clk  in  1  single system clock, 39 MHz nominal.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 record_start  in  1  start request, level sampled each cycle.
REQ-008 record_stop  in  1  stop request, level sampled each cycle.
REQ-009 adc_conv  out  1  one-cycle conversion strobe for channel adc_ch.
REQ-010 adc_ch  out  CH_W=$clog2(NUM_CH)  channel being converted.
REQ-011 adc_data  in  DATA_W  sample, valid when adc_valid=1.
REQ-012 adc_valid  in  1  one-cycle sample strobe.
REQ-013 m_data / m_ch / m_frame  out  DATA_W / CH_W / 16  output sample, channel tag, frame number.
REQ-014 m_valid  out  1, m_ready  in  1  valid/ready output stream.
REQ-015 recording  out  1  high from start acceptance until return to IDLE.
REQ-016 overflow / overrun / timeout_err  out  1 each  sticky error flags.

Function
REQ-017 FSM states SHALL be IDLE, CONV, WAIT_DATA, WAIT_TICK.
REQ-018 IDLE: record_start=1 and record_stop=0 -> CONV next cycle, recording=1, channel=0, frame=0, divider cleared, sticky flags cleared; start and stop both high -> stay IDLE.
REQ-019 CONV: adc_conv=1 for exactly one cycle with adc_ch=current channel, then WAIT_DATA.
REQ-020 WAIT_DATA: adc_valid -> capture sample; channel<NUM_CH-1 -> increment channel, CONV; else -> WAIT_TICK, channel=0.
REQ-021 WAIT_DATA: ADC_TIMEOUT cycles without adc_valid -> set timeout_err, emit nothing for that channel, advance as REQ-020.
REQ-022 Divider counts 0..SAMPLE_DIV-1 while recording, wrapping; wrap = frame tick; WAIT_TICK on tick -> frame+1 (wraps 65535->0), CONV.
REQ-023 Tick while not in WAIT_TICK -> set overrun, tick discarded, current frame completes, next frame waits for following tick.
REQ-024 record_stop high while recording -> stop_pending set; current frame completes; WAIT_TICK with stop_pending -> IDLE same cycle; recording=0 on entry to IDLE.
REQ-025 record_start while recording -> ignored.
REQ-026 Output register: captured sample loads m_data/m_ch/m_frame, m_valid=1 the cycle after adc_valid; holds until m_valid&&m_ready.
REQ-027 Capture while m_valid=1 and m_ready=0 -> new sample dropped, overflow set; capture in same cycle as accepted handshake -> loaded, no overflow.
REQ-028 Pending output not yet accepted on return to IDLE SHALL remain valid until accepted.

Reset
REQ-029 rstn low asynchronously forces IDLE; adc_conv, m_valid, recording, overflow, overrun, timeout_err=0; adc_ch, m_ch, m_frame, m_data, divider, stop_pending=0.
REQ-030 Reset mid-frame SHALL discard the frame and any pending output; no adc_conv until a new record_start.

Structure
REQ-031 Shared package seeg_pkg SHALL hold the FSM state enum, default parameter values and the 16-bit frame width constant.
REQ-032 The divider/tick generator SHALL be sub-module seeg_tick_gen (clk, rstn, enable, tick).

Verification (NUM_CH=4, DATA_W=16, SAMPLE_DIV=100, ADC_TIMEOUT=8, ADC model returns 0x1000+ch 3 cycles after adc_conv)
REQ-033 start pulse, m_ready=1 -> adc_conv for ch 0..3 in frame 0, outputs 0x1000..0x1003 tagged frame 0; next frame begins 100 cycles after start.
REQ-034 stop asserted mid-frame 2 -> all 4 samples of frame 2 emitted, recording drops before frame 3, no further adc_conv.
REQ-035 ADC silent on ch 2 -> timeout_err=1 after 8 cycles, frame outputs only ch 0,1,3.
REQ-036 m_ready=0 for whole frame -> first sample held (0x1000), overflow=1, after m_ready=1 exactly one output.
REQ-037 SAMPLE_DIV=16 (below frame duration) -> overrun=1, frame numbers increment by 1 without gaps.
REQ-038 rstn low during WAIT_DATA of ch 1 -> all outputs 0 immediately; after release, idle until record_start; start+stop same cycle -> stays IDLE.
